// File: rtl/dat_mem_arbiter_if.sv
// One requester port of the dat_mem arbiter: request/command bundle toward the arbiter
// and grant/read-data return toward the requester.
interface dat_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dat_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port dat_mem, with a bounded
// ownership lock so one port can issue multi-access sequences without interleaving.
module dat_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  dat_mem_arbiter_if.slave p0,
  dat_mem_arbiter_if.slave p1,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i
);

  localparam int CTW = $clog2(MAX_LOCK) + 1;
  localparam logic [CTW-1:0] CT_LIMIT = CTW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e         state_q, state_d, target_s;
  logic           rr_last_q, rr_last_d;
  logic [CTW-1:0] lock_ct_q, lock_ct_d;
  logic           gnt0_raw_s, gnt1_raw_s;
  logic           gnt0_s, gnt1_s, any_gnt_s;
  logic           win_lock_s, other_req_s;
  logic           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grant selection: round-robin when idle, owner-only while locked
  always_comb begin
    gnt0_raw_s = 1'b0;
    gnt1_raw_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0.req && p1.req) begin
          gnt0_raw_s = rr_last_q;
          gnt1_raw_s = ~rr_last_q;
        end else begin
          gnt0_raw_s = p0.req;
          gnt1_raw_s = p1.req;
        end
      end
      LOCK0:   gnt0_raw_s = p0.req;
      LOCK1:   gnt1_raw_s = p1.req;
      default: begin
        gnt0_raw_s = 1'b0;
        gnt1_raw_s = 1'b0;
      end
    endcase
  end

  assign gnt0_s    = gnt0_raw_s & ~reset_i;
  assign gnt1_s    = gnt1_raw_s & ~reset_i;
  assign any_gnt_s = gnt0_s | gnt1_s;

  // Memory command mux from the winning port; all-zero when nothing is granted
  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    mem_wr_o   = 1'b0;
    mem_rd_o   = 1'b0;
    if (gnt0_s) begin
      mem_addr_o = p0.addr;
      mem_din_o  = p0.wdata;
      mem_wr_o   = p0.we;
      mem_rd_o   = ~p0.we;
    end else if (gnt1_s) begin
      mem_addr_o = p1.addr;
      mem_din_o  = p1.wdata;
      mem_wr_o   = p1.we;
      mem_rd_o   = ~p1.we;
    end else begin
      mem_addr_o = '0;
      mem_din_o  = '0;
    end
  end

  assign win_lock_s  = gnt1_s ? p1.lock : p0.lock;
  assign other_req_s = gnt1_s ? p0.req  : p1.req;

  // Ownership FSM, round-robin pointer and starvation counter
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    lock_ct_d = lock_ct_q;
    target_s  = state_q;
    if (any_gnt_s) begin
      rr_last_d = gnt1_s;
      if ((lock_ct_q == CT_LIMIT) || !win_lock_s) begin
        target_s = IDLE;
      end else begin
        target_s = gnt1_s ? LOCK1 : LOCK0;
      end
      state_d = target_s;
      // The grant that opens a lock already counts against the waiting port
      if (target_s == IDLE) begin
        lock_ct_d = '0;
      end else if (target_s != state_q) begin
        lock_ct_d = other_req_s ? CTW'(1) : '0;
      end else if (other_req_s) begin
        lock_ct_d = lock_ct_q + CTW'(1);
      end else begin
        lock_ct_d = lock_ct_q;
      end
    end else begin
      case (state_q)
        LOCK0: begin
          if (!p0.lock && !p0.req) begin
            state_d   = IDLE;
            lock_ct_d = '0;
          end else begin
            state_d = LOCK0;
          end
        end
        LOCK1: begin
          if (!p1.lock && !p1.req) begin
            state_d   = IDLE;
            lock_ct_d = '0;
          end else begin
            state_d = LOCK1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Read return path: capture combinational memory data on a read grant
  always_comb begin
    rvalid0_d = gnt0_s & ~p0.we;
    rvalid1_d = gnt1_s & ~p1.we;
    if (rvalid0_d) begin
      rdata0_d = mem_dout_i;
    end else begin
      rdata0_d = rdata0_q;
    end
    if (rvalid1_d) begin
      rdata1_d = mem_dout_i;
    end else begin
      rdata1_d = rdata1_q;
    end
  end

  // State and read-return registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      lock_ct_q <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      lock_ct_q <= lock_ct_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // A read granted just before reset must not report valid during the reset cycle
  assign p0.gnt    = gnt0_s;
  assign p1.gnt    = gnt1_s;
  assign p0.rvalid = rvalid0_q & ~reset_i;
  assign p1.rvalid = rvalid1_q & ~reset_i;
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Directed scoreboard bench for dat_mem_arbiter with a behavioural dat_mem.
module tb_dat_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_rd, mem_wr;
  logic [7:0] mem [256];

  int nchecks = 0;
  int nerr    = 0;

  typedef struct packed {
    logic g0;
    logic g1;
    logic wr;
    logic rd;
  } gexp_t;

  gexp_t      gq[$];
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];

  dat_mem_arbiter_if #(.AW(8), .DW(8)) if0 ();
  dat_mem_arbiter_if #(.AW(8), .DW(8)) if1 ();

  dat_mem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(16)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .p0         (if0),
    .p1         (if1),
    .mem_addr_o (mem_addr),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
  end
  assign mem_dout = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [7:0] a1, input logic [7:0] d1,
                       input logic eg0, input logic eg1);
    gexp_t e;
    if0.req = r0; if0.we = w0; if0.lock = l0; if0.addr = a0; if0.wdata = d0;
    if1.req = r1; if1.we = w1; if1.lock = l1; if1.addr = a1; if1.wdata = d1;
    e.g0 = eg0;
    e.g1 = eg1;
    e.wr = (eg0 & w0) | (eg1 & w1);
    e.rd = (eg0 & ~w0) | (eg1 & ~w1);
    gq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: grant/command trace and read returns, checked mid-cycle
  always @(negedge clk) begin
    gexp_t e;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      chk("gnt0_gnt1_wr_rd", {28'd0, if0.gnt, if1.gnt, mem_wr, mem_rd}, {28'd0, e});
    end
    if (if0.rvalid) begin
      if (rq0.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL rvalid0_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        chk("rdata0", {24'd0, if0.rdata}, {24'd0, rq0.pop_front()});
      end
    end
    if (if1.rvalid) begin
      if (rq1.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL rvalid1_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        chk("rdata1", {24'd0, if1.rdata}, {24'd0, rq1.pop_front()});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    if0.req = 1'b0; if0.we = 1'b0; if0.lock = 1'b0; if0.addr = 8'h00; if0.wdata = 8'h00;
    if1.req = 1'b0; if1.we = 1'b0; if1.lock = 1'b0; if1.addr = 8'h00; if1.wdata = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset: requests present but nothing may be granted or written
    drive(1'b1, 1'b1, 1'b0, 8'h70, 8'h33, 1'b1, 1'b1, 1'b0, 8'h71, 8'h44, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h70, 8'h33, 1'b1, 1'b1, 1'b0, 8'h71, 8'h44, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rdata0_reset", {24'd0, if0.rdata}, 32'd0);
    chk("rdata1_reset", {24'd0, if1.rdata}, 32'd0);

    // Write then read same address on port 0
    drive(1'b1, 1'b1, 1'b0, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    rq0.push_back(8'h5A);
    drive(1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Fresh reset, then alternating grants with both ports busy
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h20, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h20, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 1'b0);
    rq1.push_back(8'h5A);
    drive(1'b1, 1'b1, 1'b0, 8'h21, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h21, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0);
    rq1.push_back(8'hA0);
    drive(1'b1, 1'b1, 1'b0, 8'h22, 8'hA2, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1);

    // Three locked accesses by port 0 while port 1 waits
    drive(1'b1, 1'b1, 1'b1, 8'h22, 8'hA2, 1'b1, 1'b1, 1'b0, 8'h23, 8'hB3, 1'b1, 1'b0);
    rq0.push_back(8'hA2);
    drive(1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b1, 1'b1, 1'b0, 8'h23, 8'hB3, 1'b1, 1'b0);
    rq0.push_back(8'hA1);
    drive(1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 1'b1, 1'b1, 1'b0, 8'h23, 8'hB3, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h23, 8'h00, 1'b1, 1'b1, 1'b0, 8'h23, 8'hB3, 1'b0, 1'b1);
    rq0.push_back(8'hB3);
    drive(1'b1, 1'b0, 1'b0, 8'h23, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Lock holder idle: the other port still waits until the lock is released
    rq0.push_back(8'h5A);
    drive(1'b1, 1'b0, 1'b1, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0);
    rq1.push_back(8'h5A);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b1);

    // Starvation guard: exactly 16 locked grants, then port 1
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i),
            1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 1'b0);
    end
    rq1.push_back(8'h5A);
    drive(1'b1, 1'b1, 1'b0, 8'h50, 8'hD5, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h50, 8'hD5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    rq0.push_back(8'hCF);
    drive(1'b1, 1'b0, 1'b0, 8'h4F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset in LOCK1 right after a port 1 read grant
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h60, 8'hD0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h60, 8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h60, 8'h00, 1'b1, 1'b1, 1'b1, 8'h60, 8'h99, 1'b0, 1'b0);
    rst = 1'b0;
    rq0.push_back(8'hD0);
    drive(1'b1, 1'b0, 1'b0, 8'h60, 8'h00, 1'b1, 1'b1, 1'b0, 8'h60, 8'h99, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h60, 8'h99, 1'b0, 1'b1);
    rq0.push_back(8'h99);
    drive(1'b1, 1'b0, 1'b0, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Both ports write addr 4 together: port 1 first (22), then port 0 (11)
    drive(1'b1, 1'b1, 1'b0, 8'h04, 8'h11, 1'b1, 1'b1, 1'b0, 8'h04, 8'h22, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h04, 8'h11, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 1'b1, 1'b0);
    rq1.push_back(8'h11);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end

    chk("mem4_final", {24'd0, mem[4]}, 32'h11);
    chk("mem70_no_reset_write", {24'd0, mem[8'h70]}, 32'h00);
    chk("mem4f_locked_write", {24'd0, mem[8'h4F]}, 32'hCF);
    chk("rq0_drained", rq0.size(), 32'd0);
    chk("rq1_drained", rq1.size(), 32'd0);
    chk("gq_drained", gq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
